// File: rtl/mac_rx_stream_checker.sv
// Passive protocol checker for the MAC RX stream: sticky error bits, error/frame counters.
// Define MAC_RX_CHK_SVA_EN to add per-error-bit assertions and a minimum-length frame cover.
module mac_rx_stream_checker #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MIN_LEN   = 64,
    parameter int unsigned MAX_LEN   = 1518,
    parameter int unsigned STALL_MAX = 256,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_last,
    input  logic              clr,
    output logic [4:0]        err_sticky,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  frame_count
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 2);
    localparam int unsigned STL_W = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {IDLE, IN_FRAME, DROP} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   frame_total;
    logic [STL_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               prev_stall_q;
    logic [DATA_W-1:0]  prev_data_q;
    logic               prev_last_q;
    logic [4:0]         err_sticky_q, err_sticky_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   frame_count_q, frame_count_d;
    logic [CNT_W-1:0]   err_base, frame_base;

    logic beat, stalled;
    logic lnv_err, unstable_err, runt_err, giant_err, stall_err, good_frame;
    logic [4:0] err_vec;
    logic any_err;

    assign beat    = rx_valid && rx_ready;
    assign stalled = rx_valid && !rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    // An IDLE last-beat is a one-beat frame, so both states share the length classification.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        runt_err    = 1'b0;
        giant_err   = 1'b0;
        good_frame  = 1'b0;
        frame_total = (state_q == IN_FRAME) ? len_q + 1'b1 : LEN_W'(1);
        if (beat) begin
            case (state_q)
                IDLE, IN_FRAME: begin
                    if (rx_last) begin
                        if (frame_total < LEN_W'(MIN_LEN))      runt_err   = 1'b1;
                        else if (frame_total > LEN_W'(MAX_LEN)) giant_err  = 1'b1;
                        else                                    good_frame = 1'b1;
                        state_d = IDLE;
                        len_d   = '0;
                    end else if (state_q == IN_FRAME && len_q == LEN_W'(MAX_LEN)) begin
                        giant_err = 1'b1;
                        state_d   = DROP;
                    end else begin
                        state_d = IN_FRAME;
                        len_d   = frame_total;
                    end
                end
                default: begin
                    if (rx_last) begin
                        state_d = IDLE;
                        len_d   = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        lnv_err      = rx_last && !rx_valid;
        unstable_err = prev_stall_q &&
                       (!rx_valid || rx_data != prev_data_q || rx_last != prev_last_q);
        stall_err    = stalled && (stall_cnt_q == STL_W'(STALL_MAX - 1));
        if (!stalled)                                stall_cnt_d = '0;
        else if (stall_cnt_q == STL_W'(STALL_MAX))   stall_cnt_d = stall_cnt_q;
        else                                         stall_cnt_d = stall_cnt_q + 1'b1;

        err_vec     = {stall_err, giant_err, runt_err, unstable_err, lnv_err};
        any_err     = |err_vec;
        err_pulse_d = any_err;

        // clr wipes the old state first so a same-cycle error still lands.
        err_sticky_d  = (clr ? 5'b0 : err_sticky_q) | err_vec;
        err_base      = clr ? '0 : err_count_q;
        frame_base    = clr ? '0 : frame_count_q;
        err_count_d   = (any_err && err_base != '1) ? err_base + 1'b1 : err_base;
        frame_count_d = (good_frame && frame_base != '1) ? frame_base + 1'b1 : frame_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q   <= '0;
            prev_stall_q  <= 1'b0;
            prev_data_q   <= '0;
            prev_last_q   <= 1'b0;
            err_sticky_q  <= '0;
            err_pulse_q   <= 1'b0;
            err_count_q   <= '0;
            frame_count_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            prev_stall_q  <= stalled;
            prev_data_q   <= rx_data;
            prev_last_q   <= rx_last;
            err_sticky_q  <= err_sticky_d;
            err_pulse_q   <= err_pulse_d;
            err_count_q   <= err_count_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign err_sticky  = err_sticky_q;
    assign err_pulse   = err_pulse_q;
    assign err_count   = err_count_q;
    assign frame_count = frame_count_q;

`ifdef MAC_RX_CHK_SVA_EN
    a_last_no_valid: assert property (@(posedge clk) disable iff (!rst_n) !lnv_err)
        else $error("LAST_NO_VALID");
    a_unstable: assert property (@(posedge clk) disable iff (!rst_n) !unstable_err)
        else $error("UNSTABLE");
    a_runt: assert property (@(posedge clk) disable iff (!rst_n) !runt_err)
        else $error("RUNT");
    a_giant: assert property (@(posedge clk) disable iff (!rst_n) !giant_err)
        else $error("GIANT");
    a_stall: assert property (@(posedge clk) disable iff (!rst_n) !stall_err)
        else $error("STALL");
    c_min_len_frame: cover property (@(posedge clk) disable iff (!rst_n)
        good_frame && frame_total == LEN_W'(MIN_LEN));
`else
`endif

endmodule

// File: tb/tb_mac_rx_stream_checker.sv
// Directed bench for mac_rx_stream_checker: frame-level reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_mac_rx_stream_checker;

  localparam int MIN_LEN   = 64;
  localparam int MAX_LEN   = 1518;
  localparam int STALL_MAX = 256;
  localparam int CNT_SAT   = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_valid = 1'b0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_last = 1'b0;
  logic        clr = 1'b0;
  logic [4:0]  err_sticky;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  mac_rx_stream_checker #(
    .DATA_W(8), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .STALL_MAX(STALL_MAX), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_last(rx_last), .clr(clr),
    .err_sticky(err_sticky), .err_pulse(err_pulse),
    .err_count(err_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Reference model: frame length as a plain beat count, stall as a run length.
  int         m_flen = 0;
  bit         m_dropped = 0;
  int         m_run = 0;
  bit         m_pstall = 0;
  logic [7:0] m_pdata = '0;
  bit         m_plast = 0;
  logic [4:0] m_sticky = '0;
  bit         m_pulse = 0;
  int         m_ecnt = 0;
  int         m_fcnt = 0;
  logic [4:0] m_e;
  bit         m_good;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flen = 0; m_dropped = 0; m_run = 0; m_pstall = 0; m_pdata = '0; m_plast = 0;
      m_sticky = '0; m_pulse = 0; m_ecnt = 0; m_fcnt = 0;
    end else begin
      m_e = '0;
      m_good = 0;
      if (rx_last && !rx_valid) m_e[0] = 1'b1;
      if (m_pstall && (!rx_valid || rx_data != m_pdata || rx_last != m_plast)) m_e[1] = 1'b1;
      if (rx_valid && !rx_ready) begin
        m_run++;
        if (m_run == STALL_MAX) m_e[4] = 1'b1;
      end else m_run = 0;
      if (rx_valid && rx_ready) begin
        m_flen++;
        if (rx_last) begin
          if (!m_dropped) begin
            if (m_flen < MIN_LEN) m_e[2] = 1'b1;
            else if (m_flen > MAX_LEN) m_e[3] = 1'b1;
            else m_good = 1;
          end
          m_flen = 0;
          m_dropped = 0;
        end else if (!m_dropped && m_flen > MAX_LEN) begin
          m_e[3] = 1'b1;
          m_dropped = 1;
        end
      end
      if (clr) begin
        m_sticky = m_e;
        m_ecnt = (m_e != 0) ? 1 : 0;
        m_fcnt = m_good ? 1 : 0;
      end else begin
        m_sticky = m_sticky | m_e;
        if (m_e != 0 && m_ecnt < CNT_SAT) m_ecnt++;
        if (m_good && m_fcnt < CNT_SAT) m_fcnt++;
      end
      m_pulse = (m_e != 0);
      m_pstall = rx_valid && !rx_ready;
      m_pdata = rx_data;
      m_plast = rx_last;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("err_sticky", 32'(err_sticky), 32'(m_sticky));
      check("err_pulse", 32'(err_pulse), 32'(m_pulse));
      check("err_count", 32'(err_count), 32'(m_ecnt));
      check("frame_count", 32'(frame_count), 32'(m_fcnt));
    end
  end

  task automatic cyc(input logic v, input logic r, input logic [7:0] d, input logic l);
    rx_valid = v; rx_ready = r; rx_data = d; rx_last = l;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 8'(i), (i == n - 1));
    idle(1);
  endtask

  task automatic do_clr;
    clr = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    clr = 1'b0;
  endtask

  task automatic lit_outputs(input string tag, input logic [4:0] st, input int ec, input int fc);
    check({tag, "_sticky"}, 32'(err_sticky), 32'(st));
    check({tag, "_count"}, 32'(err_count), 32'(ec));
    check({tag, "_frames"}, 32'(frame_count), 32'(fc));
    check({tag, "_model_sticky"}, 32'(m_sticky), 32'(st));
    check({tag, "_model_count"}, 32'(m_ecnt), 32'(ec));
    check({tag, "_model_frames"}, 32'(m_fcnt), 32'(fc));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lit_outputs("reset", 5'b00000, 0, 0);
    check("reset_pulse", 32'(err_pulse), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // LAST_NO_VALID for one cycle
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    lit_outputs("lnv", 5'b00001, 1, 0);
    check("lnv_pulse_hi", 32'(err_pulse), 32'd1);
    idle(1);
    check("lnv_pulse_lo", 32'(err_pulse), 32'd0);

    // RUNT then a minimum-length good frame
    do_clr();
    frame(63);
    lit_outputs("runt63", 5'b00100, 1, 0);
    frame(64);
    lit_outputs("good64", 5'b00100, 1, 1);

    // GIANT via the drop path, then boundary lengths
    do_clr();
    frame(1520);
    lit_outputs("giant1520", 5'b01000, 1, 0);
    frame(64);
    lit_outputs("after_giant", 5'b01000, 1, 1);
    frame(1518);
    lit_outputs("max1518", 5'b01000, 1, 2);
    frame(1519);
    lit_outputs("giant1519", 5'b01000, 2, 2);
    frame(1);
    lit_outputs("runt1", 5'b01100, 3, 2);

    // UNSTABLE data during stall, then a long stall
    do_clr();
    cyc(1'b1, 1'b0, 8'hA5, 1'b0);
    cyc(1'b1, 1'b0, 8'hA5, 1'b0);
    cyc(1'b1, 1'b0, 8'h5A, 1'b0);
    lit_outputs("unstable", 5'b00010, 1, 0);
    for (int i = 0; i < 260; i++) cyc(1'b1, 1'b0, 8'h5A, 1'b0);
    cyc(1'b1, 1'b1, 8'h5A, 1'b0);
    idle(1);
    lit_outputs("stall", 5'b10010, 2, 0);

    // Reset mid-frame
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    lit_outputs("midreset", 5'b00000, 0, 0);
    check("midreset_pulse", 32'(err_pulse), 32'd0);
    rst_n = 1'b1;
    idle(1);
    frame(64);
    lit_outputs("post_reset", 5'b00000, 0, 1);

    // clr coincident with an error, then saturation
    do_clr();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);
    lit_outputs("five", 5'b00001, 5, 0);
    clr = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    clr = 1'b0;
    lit_outputs("clr_err", 5'b00001, 1, 0);
    for (int i = 0; i < 65540; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);
    lit_outputs("saturate", 5'b00001, CNT_SAT, 0);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
